// File: rtl/cache_arbiter_pkg.sv
// Shared types and widths for the cache-to-memory arbiter.
package arbiter_pkg;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RELEASE} arb_state_t;
  typedef enum logic {CLIENT_I, CLIENT_D} arb_client_t;
endpackage

// File: rtl/arbiter_select.sv
// Combinational winner picker. Define ARBITER_ROUND_ROBIN_EN for alternating
// priority on simultaneous requests; default is fixed D-over-I priority.
module arbiter_select
  import arbiter_pkg::*;
(
  input  logic        i_req,
  input  logic        d_req,
  input  arb_client_t last_grant,
  output arb_client_t winner
);

`ifdef ARBITER_ROUND_ROBIN_EN
  always_comb begin
    winner = CLIENT_I;
    if (i_req && d_req) begin
      winner = (last_grant == CLIENT_D) ? CLIENT_I : CLIENT_D;
    end else if (d_req) begin
      winner = CLIENT_D;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    winner = CLIENT_I;
    if (d_req) begin
      winner = CLIENT_D;
    end
  end
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Two-client (I-cache / D-cache) physical memory arbiter with a registered
// memory side and a one-cycle RELEASE gap. Optional: ARBITER_ROUND_ROBIN_EN.
module cache_arbiter
  import arbiter_pkg::*;
#(
  parameter int s_line = LINE_W,
  parameter int s_addr = ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [s_addr-1:0] i_pmem_address,
  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [s_line-1:0] i_pmem_wdata,
  output logic [s_line-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic [s_addr-1:0] d_pmem_address,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic [s_line-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic [s_addr-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [s_line-1:0] mem_wdata,
  input  logic [s_line-1:0] mem_rdata,
  input  logic              mem_resp,
  output arb_state_t        dbg_state
);

  arb_state_t  state, state_next;
  arb_client_t winner, last_grant;
  logic        i_req, d_req;
  logic        grant, done;
  logic [s_addr-1:0] req_address;
  logic [s_line-1:0] req_wdata;
  logic        req_read, req_write;

  assign i_req = i_pmem_read | i_pmem_write;
  assign d_req = d_pmem_read | d_pmem_write;

  arbiter_select u_select (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .winner     (winner)
  );

  // Winner's request; a write wins over a simultaneous read.
  always_comb begin
    req_address = i_pmem_address;
    req_wdata   = i_pmem_wdata;
    req_write   = i_pmem_write;
    req_read    = i_pmem_read & ~i_pmem_write;
    if (winner == CLIENT_D) begin
      req_address = d_pmem_address;
      req_wdata   = d_pmem_wdata;
      req_write   = d_pmem_write;
      req_read    = d_pmem_read & ~d_pmem_write;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant      = 1'b1;
          state_next = (winner == CLIENT_D) ? D_BUSY : I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp) begin
          done       = 1'b1;
          state_next = RELEASE;
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory-side registers: loaded on grant, strobes dropped on completion,
  // address and data left in place through RELEASE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end else if (grant) begin
      mem_address <= req_address;
      mem_wdata   <= req_wdata;
      mem_read    <= req_read;
      mem_write   <= req_write;
    end else if (done) begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end
  end

`ifdef ARBITER_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_grant <= CLIENT_I;
    else if (grant) last_grant <= winner;
  end
`else
  assign last_grant = CLIENT_I;
`endif

  assign i_pmem_resp  = (state == I_BUSY) & mem_resp;
  assign d_pmem_resp  = (state == D_BUSY) & mem_resp;
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;
  assign dbg_state    = state;

endmodule
